// File: rtl/decode_cycle.sv
// decode_cycle: RISC-V style decode stage with register file and D->E pipeline register.
// Decodes lw/sw/R-type/I-ALU/beq/jal into a 10-bit control bundle, reads two operands,
// builds the sign-extended immediate and registers everything into the E stage.
// Optional feature: define DECODE_BYPASS_EN to forward a same-cycle writeback to the reads.
`timescale 1ns/1ps

module decode_cycle #(
    parameter int PC_W = 9,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FlushE,
    input  logic [XLEN-1:0] InstrD,
    input  logic [PC_W-1:0] PCD,
    input  logic [PC_W-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [9:0]      CtrlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [PC_W-1:0] PCE,
    output logic [PC_W-1:0] PCPlus4E,
    output logic            ValidE
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_LOAD,
        CLS_STORE,
        CLS_RTYPE,
        CLS_IALU,
        CLS_BRANCH,
        CLS_JAL
    } cls_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_t;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       funct7b5;

    assign opcode   = InstrD[6:0];
    assign rd       = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign funct7b5 = InstrD[30];

    // Decoded D-stage signals
    cls_t            cls;
    imm_t            imm_src;
    alu_t            alu_ctrl;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic            alu_from_funct;
    logic            valid_d;
    logic [9:0]      ctrl_d;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;

    logic [XLEN-1:0] rf [32];

    // Classify the opcode; anything unlisted becomes a bubble
    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_RTYPE:  cls = CLS_RTYPE;
            OP_IALU:   cls = CLS_IALU;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            default:   cls = CLS_NONE;
        endcase
    end

    // Main control decode per instruction class
    always_comb begin
        reg_write      = 1'b0;
        result_src     = 2'b00;
        mem_write      = 1'b0;
        jump           = 1'b0;
        branch         = 1'b0;
        alu_src        = 1'b0;
        alu_from_funct = 1'b0;
        imm_src        = IMM_NONE;
        valid_d        = 1'b1;
        case (cls)
            CLS_LOAD: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                alu_src    = 1'b1;
                imm_src    = IMM_I;
            end
            CLS_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            CLS_RTYPE: begin
                reg_write      = 1'b1;
                alu_from_funct = 1'b1;
            end
            CLS_IALU: begin
                reg_write      = 1'b1;
                alu_src        = 1'b1;
                alu_from_funct = 1'b1;
                imm_src        = IMM_I;
            end
            CLS_BRANCH: begin
                branch  = 1'b1;
                imm_src = IMM_B;
            end
            CLS_JAL: begin
                reg_write  = 1'b1;
                result_src = 2'b10;
                jump       = 1'b1;
                imm_src    = IMM_J;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // ALU operation: fixed add/sub for memory/branch/jump, funct3-driven for ALU ops
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (cls == CLS_BRANCH) begin
            alu_ctrl = ALU_SUB;
        end else if (alu_from_funct) begin
            case (funct3)
                3'b000:  alu_ctrl = (cls == CLS_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_ctrl = ALU_SLT;
                3'b110:  alu_ctrl = ALU_OR;
                3'b111:  alu_ctrl = ALU_AND;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

    assign ctrl_d = {reg_write, result_src, mem_write, jump, branch, alu_ctrl, alu_src};

    // Immediate generation, sign-extended from InstrD[31]
    always_comb begin
        imm_d = '0;
        case (imm_src)
            IMM_I:   imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                              InstrD[11:8], 1'b0};
            IMM_J:   imm_d = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                              InstrD[30:21], 1'b0};
            default: imm_d = '0;
        endcase
    end

    // Register file write port; x0 is never written, reset clears every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            rf[RdW] <= ResultW;
        end
    end

    // Combinational read ports; x0 always reads zero
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
`ifdef DECODE_BYPASS_EN
        if (rs1 != 5'd0) begin
            rd1_d = (RegWriteW && (RdW == rs1)) ? ResultW : rf[rs1];
        end
        if (rs2 != 5'd0) begin
            rd2_d = (RegWriteW && (RdW == rs2)) ? ResultW : rf[rs2];
        end
`else
        if (rs1 != 5'd0) begin
            rd1_d = rf[rs1];
        end
        if (rs2 != 5'd0) begin
            rd2_d = rf[rs2];
        end
`endif
    end

    // D->E pipeline register; flush loads an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CtrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ValidE   <= 1'b0;
        end else if (FlushE) begin
            CtrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ValidE   <= 1'b0;
        end else begin
            CtrlE    <= valid_d ? ctrl_d : '0;
            RD1E     <= rd1_d;
            RD2E     <= rd2_d;
            ImmExtE  <= imm_d;
            Rs1E     <= rs1;
            Rs2E     <= rs2;
            RdE      <= rd;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            ValidE   <= valid_d;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: scoreboard bench for decode_cycle.
// Stimulus pushes hand-computed E-stage expectations; a monitor pops one per clock edge.
`timescale 1ns/1ps

module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic        FlushE;
    logic [31:0] InstrD;
    logic [8:0]  PCD;
    logic [8:0]  PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [9:0]  CtrlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [8:0]  PCE;
    logic [8:0]  PCPlus4E;
    logic        ValidE;

    int tests;
    int fails;

    typedef struct packed {
        logic [7:0]  id;
        logic [9:0]  ctrl;
        logic        valid;
        logic [8:0]  pc;
        logic [8:0]  pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        cd;
        logic        ci;
        logic        cf;
    } exp_t;

    exp_t exp_q[$];

    decode_cycle #(.PC_W(9), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .FlushE(FlushE), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ValidE(ValidE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] id, input logic [31:0] act,
                       input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL vec%0d %s actual=%h expected=%h", id, name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] id, input logic [9:0] ctrl, input logic valid,
                                input logic [8:0] pc, input logic [8:0] pc4,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic cd, input logic ci, input logic cf);
        exp_t e;
        e.id = id; e.ctrl = ctrl; e.valid = valid; e.pc = pc; e.pc4 = pc4;
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.cd = cd; e.ci = ci; e.cf = cf;
        return e;
    endfunction

    task automatic cycle(input logic [31:0] instr, input logic [8:0] pc, input logic flush,
                         input logic we, input logic [4:0] rdw, input logic [31:0] res,
                         input exp_t e);
        @(negedge clk);
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 9'd4;
        FlushE    = flush;
        RegWriteW = we;
        RdW       = rdw;
        ResultW   = res;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input logic [7:0] id);
        chk("rst_CtrlE", id, {22'd0, CtrlE}, 32'd0);
        chk("rst_RD1E", id, RD1E, 32'd0);
        chk("rst_RD2E", id, RD2E, 32'd0);
        chk("rst_ImmExtE", id, ImmExtE, 32'd0);
        chk("rst_Rs1E", id, {27'd0, Rs1E}, 32'd0);
        chk("rst_Rs2E", id, {27'd0, Rs2E}, 32'd0);
        chk("rst_RdE", id, {27'd0, RdE}, 32'd0);
        chk("rst_PCE", id, {23'd0, PCE}, 32'd0);
        chk("rst_PCPlus4E", id, {23'd0, PCPlus4E}, 32'd0);
        chk("rst_ValidE", id, {31'd0, ValidE}, 32'd0);
    endtask

    // Monitor: after each rising edge, compare E outputs against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("CtrlE", e.id, {22'd0, CtrlE}, {22'd0, e.ctrl});
                chk("ValidE", e.id, {31'd0, ValidE}, {31'd0, e.valid});
                chk("PCE", e.id, {23'd0, PCE}, {23'd0, e.pc});
                chk("PCPlus4E", e.id, {23'd0, PCPlus4E}, {23'd0, e.pc4});
                if (e.cd) begin
                    chk("RD1E", e.id, RD1E, e.rd1);
                    chk("RD2E", e.id, RD2E, e.rd2);
                end
                if (e.ci) chk("ImmExtE", e.id, ImmExtE, e.imm);
                if (e.cf) begin
                    chk("Rs1E", e.id, {27'd0, Rs1E}, {27'd0, e.rs1});
                    chk("Rs2E", e.id, {27'd0, Rs2E}, {27'd0, e.rs2});
                    chk("RdE", e.id, {27'd0, RdE}, {27'd0, e.rd});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    localparam logic [9:0] C_ADD  = 10'b1000000000;
    localparam logic [31:0] D     = 32'hDEADBEEF;

    initial begin
        logic [31:0] hz;
        logic [4:0]  r2;
        logic [8:0]  pc;
        logic [7:0]  id;
`ifdef DECODE_BYPASS_EN
        hz = 32'h0000_1234;
`else
        hz = 32'h0000_00AA;
`endif
        rst = 1'b1; FlushE = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        #2;
        chk_all_zero(8'd0);
        @(negedge clk);
        rst = 1'b0;

        // illegal opcode 0 while writing x5
        cycle(32'h0000_0000, 9'h010, 0, 1, 5'd5, 32'hAA,
              mk(1, 10'd0, 0, 9'h010, 9'h014, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        // add x6,x5,x5
        cycle(32'h0052_8333, 9'h014, 0, 0, 5'd0, 32'h0,
              mk(2, C_ADD, 1, 9'h014, 9'h018, 32'hAA, 32'hAA, 0, 5, 5, 6, 1, 0, 1));
        // same-cycle write of x5 while reading it
        cycle(32'h0052_8333, 9'h018, 0, 1, 5'd5, 32'h1234,
              mk(3, C_ADD, 1, 9'h018, 9'h01C, hz, hz, 0, 5, 5, 6, 1, 0, 1));
        cycle(32'h0052_8333, 9'h01C, 0, 0, 5'd0, 32'h0,
              mk(4, C_ADD, 1, 9'h01C, 9'h020, 32'h1234, 32'h1234, 0, 5, 5, 6, 1, 0, 1));
        // lw x1,-4(x2)
        cycle(32'hFFC1_2083, 9'h020, 0, 0, 5'd0, 32'h0,
              mk(5, 10'b1010000001, 1, 9'h020, 9'h024, 0, 0, 32'hFFFF_FFFC, 2, 28, 1, 1, 1, 1));
        // beq x1,x2,-8
        cycle(32'hFE20_8CE3, 9'h024, 0, 0, 5'd0, 32'h0,
              mk(6, 10'b0000010010, 1, 9'h024, 9'h028, 0, 0, 32'hFFFF_FFF8, 1, 2, 25, 1, 1, 1));
        // flushed jal while writing x7
        cycle(32'h0080_00EF, 9'h040, 1, 1, 5'd7, D,
              mk(7, 10'd0, 0, 9'h000, 9'h000, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        // jal x1,8 unflushed
        cycle(32'h0080_00EF, 9'h044, 0, 0, 5'd0, 32'h0,
              mk(8, 10'b1100100000, 1, 9'h044, 9'h048, 0, 0, 32'h8, 0, 8, 1, 1, 1, 1));
        // addi x3,x7,5 -> x7 kept the flushed-cycle write
        cycle(32'h0053_8193, 9'h048, 0, 0, 5'd0, 32'h0,
              mk(9, 10'b1000000001, 1, 9'h048, 9'h04C, D, 32'h1234, 32'h5, 7, 5, 3, 1, 1, 1));
        // write x0 while reading it, then read again
        cycle(32'h0000_0333, 9'h04C, 0, 1, 5'd0, 32'hFFFF_FFFF,
              mk(10, C_ADD, 1, 9'h04C, 9'h050, 0, 0, 0, 0, 0, 6, 1, 0, 1));
        cycle(32'h0000_0333, 9'h050, 0, 0, 5'd0, 32'h0,
              mk(11, C_ADD, 1, 9'h050, 9'h054, 0, 0, 0, 0, 0, 6, 1, 0, 1));
        // sw x5,-12(x7)
        cycle(32'hFE53_AA23, 9'h054, 0, 0, 5'd0, 32'h0,
              mk(12, 10'b0001000001, 1, 9'h054, 9'h058, D, 32'h1234, 32'hFFFF_FFF4, 7, 5, 20, 1, 1, 1));
        // sub / or / slt / xor(unlisted -> add)
        cycle(32'h4072_8333, 9'h058, 0, 0, 5'd0, 32'h0,
              mk(13, 10'b1000000010, 1, 9'h058, 9'h05C, 32'h1234, D, 0, 5, 7, 6, 1, 0, 1));
        cycle(32'h0072_E333, 9'h05C, 0, 0, 5'd0, 32'h0,
              mk(14, 10'b1000000110, 1, 9'h05C, 9'h060, 32'h1234, D, 0, 5, 7, 6, 1, 0, 1));
        cycle(32'h0072_A333, 9'h060, 0, 0, 5'd0, 32'h0,
              mk(15, 10'b1000001010, 1, 9'h060, 9'h064, 32'h1234, D, 0, 5, 7, 6, 1, 0, 1));
        cycle(32'h0072_C333, 9'h064, 0, 0, 5'd0, 32'h0,
              mk(16, C_ADD, 1, 9'h064, 9'h068, 32'h1234, D, 0, 5, 7, 6, 1, 0, 1));
        // andi x6,x5,-1
        cycle(32'hFFF2_F313, 9'h068, 0, 0, 5'd0, 32'h0,
              mk(17, 10'b1000000101, 1, 9'h068, 9'h06C, 32'h1234, 0, 32'hFFFF_FFFF, 5, 31, 6, 1, 1, 1));
        // addi with instr[30]=1 stays add
        cycle(32'h4002_8313, 9'h06C, 0, 0, 5'd0, 32'h0,
              mk(18, 10'b1000000001, 1, 9'h06C, 9'h070, 32'h1234, 0, 32'h400, 5, 0, 6, 1, 1, 1));

        // mid-run reset with a coincident writeback to x9
        @(negedge clk);
        InstrD = 32'h0052_8333; PCD = 9'h070; PCPlus4D = 9'h074;
        RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h55;
        rst = 1'b1;
        #1;
        chk_all_zero(8'd19);
        @(negedge clk);
        rst = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;

        // all registers read back zero after reset
        id = 8'd20;
        pc = 9'h080;
        for (int r = 1; r < 32; r += 2) begin
            r2 = (r == 31) ? 5'd31 : 5'(r + 1);
            cycle({7'b0, r2, 5'(r), 3'b000, 5'd6, 7'b0110011}, pc, 0, 0, 5'd0, 32'h0,
                  mk(id, C_ADD, 1, pc, pc + 9'd4, 0, 0, 0, 5'(r), r2, 6, 1, 0, 1));
            id = id + 8'd1;
            pc = pc + 9'd4;
        end

        @(negedge clk);
        InstrD = '0;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
